// File: rtl/rgb_led_pwm.sv
// RGB LED PWM driver: double-buffered per-LED colour registers, reloaded only at
// PWM period boundaries so a colour update never produces a glitched period.

package types;
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_led_t;
endpackage

module rgb_led_pwm #(
    parameter int NUM_LEDS = 4,
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 390,
    parameter int IDX_W    = 3
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [IDX_W-1:0]                  wr_led_i,
    input  logic [WIDTH-1:0]                  wr_red_i,
    input  logic [WIDTH-1:0]                  wr_green_i,
    input  logic [WIDTH-1:0]                  wr_blue_i,
    output logic                              wr_err_o,
    output logic                              frame_o,
    output types::rgb_led_t [NUM_LEDS-1:0]    rgb_leds
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] PWM_LAST = '1;
    localparam logic [31:0]      NUM_U    = 32'(NUM_LEDS);

    // Channel layout inside each LED entry: [2] = red, [1] = green, [0] = blue.
    typedef logic [NUM_LEDS-1:0][2:0][WIDTH-1:0] duty_set_t;

    logic [DIV_W-1:0]                 div_q, div_d;
    logic [WIDTH-1:0]                 pwm_q, pwm_d;
    duty_set_t                        shadow_q, shadow_d;
    duty_set_t                        active_q, active_d;
    types::rgb_led_t [NUM_LEDS-1:0]   leds_q, leds_d;
    logic                             ready_q, ready_d;
    logic                             err_q, err_d;
    logic                             frame_q, frame_d;

    logic tick;
    logic boundary;
    logic wr_fire;
    logic idx_ok;

    always_comb begin
        tick     = (div_q == DIV_LAST);
        boundary = tick && (pwm_q == PWM_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        pwm_d    = tick ? pwm_q + 1'b1 : pwm_q;

        wr_fire  = wr_valid_i && ready_q;
        idx_ok   = (32'(wr_led_i) < NUM_U);

        shadow_d = shadow_q;
        if (wr_fire && idx_ok) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (32'(wr_led_i) == 32'(i)) begin
                    shadow_d[i] = {wr_red_i, wr_green_i, wr_blue_i};
                end
            end
        end

        // Ready is low during boundary, so the shadow is stable while it is copied.
        active_d = boundary ? shadow_q : active_q;

        // Compare against post-update values so a reloaded duty applies from step 0.
        leds_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i].r = (active_d[i][2] > pwm_d);
            leds_d[i].g = (active_d[i][1] > pwm_d);
            leds_d[i].b = (active_d[i][0] > pwm_d);
        end

        // Registered ready: low exactly in the cycle the counters will hit boundary.
        ready_d = !((div_d == DIV_LAST) && (pwm_d == PWM_LAST));
        err_d   = wr_fire && !idx_ok;
        frame_d = boundary;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_q    <= '0;
            pwm_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            leds_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            pwm_q    <= pwm_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            leds_q   <= leds_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    assign wr_ready_o = ready_q;
    assign wr_err_o   = err_q;
    assign frame_o    = frame_q;
    assign rgb_leds   = leds_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: randomized writes against a time-indexed reference
// model (counters derived arithmetically from cycles since reset release).

module tb_rgb_led_pwm;

    localparam int NUM_LEDS = 4;
    localparam int WIDTH    = 4;
    localparam int CLK_DIV  = 2;
    localparam int IDX_W    = 3;
    localparam int STEPS    = 1 << WIDTH;
    localparam int PERIOD   = CLK_DIV * STEPS;

    logic                           clk_i = 1'b0;
    logic                           rstn_i = 1'b0;
    logic                           wr_valid_i = 1'b0;
    logic                           wr_ready_o;
    logic [IDX_W-1:0]               wr_led_i = '0;
    logic [WIDTH-1:0]               wr_red_i = '0;
    logic [WIDTH-1:0]               wr_green_i = '0;
    logic [WIDTH-1:0]               wr_blue_i = '0;
    logic                           wr_err_o;
    logic                           frame_o;
    types::rgb_led_t [NUM_LEDS-1:0] rgb_leds;
    logic [3*NUM_LEDS-1:0]          leds_flat;

    assign leds_flat = rgb_leds;

    rgb_led_pwm #(
        .NUM_LEDS (NUM_LEDS),
        .WIDTH    (WIDTH),
        .CLK_DIV  (CLK_DIV),
        .IDX_W    (IDX_W)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_led_i   (wr_led_i),
        .wr_red_i   (wr_red_i),
        .wr_green_i (wr_green_i),
        .wr_blue_i  (wr_blue_i),
        .wr_err_o   (wr_err_o),
        .frame_o    (frame_o),
        .rgb_leds   (rgb_leds)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: k = clk edges since reset release; channel 0=r,1=g,2=b.
    int   k = 0;
    int   m_sh  [NUM_LEDS][3];
    int   m_act [NUM_LEDS][3];
    logic m_ready = 1'b0;
    logic m_frame = 1'b0;
    logic m_err   = 1'b0;
    logic [3*NUM_LEDS-1:0] m_leds = '0;

    int hs_dut = 0;
    int hs_exp = 0;
    int cnt [NUM_LEDS][3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < NUM_LEDS; i++)
            for (int c = 0; c < 3; c++) begin
                m_sh[i][c]  = 0;
                m_act[i][c] = 0;
            end
        m_ready = 1'b0;
        m_frame = 1'b0;
        m_err   = 1'b0;
        m_leds  = '0;
    endtask

    task automatic check_outputs();
        check_val("ready", 32'(wr_ready_o), 32'(m_ready));
        check_val("frame", 32'(frame_o), 32'(m_frame));
        check_val("err", 32'(wr_err_o), 32'(m_err));
        check_val("leds", 32'(leds_flat), 32'(m_leds));
    endtask

    // One clock cycle with the currently driven inputs, then model update and checks.
    task automatic cycle();
        bit acc;
        bit bnd;
        bit running;
        int pwm;
        int idx;
        running = (rstn_i == 1'b1);
        acc = wr_valid_i && m_ready;
        bnd = running && ((k % PERIOD) == PERIOD - 1);
        idx = int'(wr_led_i);
        if (wr_valid_i && wr_ready_o) hs_dut++;
        if (acc) hs_exp++;
        @(posedge clk_i);
        if (running) begin
            if (bnd) m_act = m_sh;
            if (acc && idx < NUM_LEDS) begin
                m_sh[idx][0] = int'(wr_red_i);
                m_sh[idx][1] = int'(wr_green_i);
                m_sh[idx][2] = int'(wr_blue_i);
            end
            m_err   = acc && (idx >= NUM_LEDS);
            m_frame = bnd;
            k++;
            pwm     = (k / CLK_DIV) % STEPS;
            m_ready = ((k % PERIOD) != PERIOD - 1);
            for (int i = 0; i < NUM_LEDS; i++)
                for (int c = 0; c < 3; c++)
                    m_leds[3*i + 2 - c] = (m_act[i][c] > pwm);
        end
        #1;
        check_outputs();
    endtask

    task automatic write(input logic [IDX_W-1:0] led, input logic [WIDTH-1:0] r,
                         input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b);
        wr_valid_i = 1'b1;
        wr_led_i   = led;
        wr_red_i   = r;
        wr_green_i = g;
        wr_blue_i  = b;
        cycle();
        wr_valid_i = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        #2;
        rstn_i = 1'b0;
        #1;
        model_reset();
        check_val("rst_async_leds", 32'(leds_flat), 32'd0);
        check_val("rst_async_ready", 32'(wr_ready_o), 32'd0);
        check_val("rst_async_frame", 32'(frame_o), 32'd0);
        repeat (hold) cycle();
        #2;
        rstn_i = 1'b1;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < PERIOD + 8 && !seen; i++) begin
            cycle();
            if (frame_o) seen = 1'b1;
        end
        check_val("frame_wait", 32'(seen), 32'd1);
    endtask

    // Counts on-cycles over one period, starting with the current (already sampled) cycle.
    task automatic count_period();
        for (int i = 0; i < NUM_LEDS; i++)
            for (int c = 0; c < 3; c++) cnt[i][c] = 0;
        for (int t = 0; t < PERIOD; t++) begin
            if (t != 0) cycle();
            for (int i = 0; i < NUM_LEDS; i++) begin
                cnt[i][0] += int'(rgb_leds[i].r);
                cnt[i][1] += int'(rgb_leds[i].g);
                cnt[i][2] += int'(rgb_leds[i].b);
            end
        end
    endtask

    initial begin
        int frames;
        int red0;
        int others;
        int low_rdy;
        model_reset();

        // Reset with a write presented during reset (must be lost).
        rstn_i = 1'b0;
        wr_valid_i = 1'b1;
        wr_led_i = 3'd0;
        wr_red_i = 4'd15;
        wr_green_i = 4'd15;
        wr_blue_i = 4'd15;
        #1;
        repeat (5) cycle();
        wr_valid_i = 1'b0;
        #2;
        rstn_i = 1'b1;
        cycle();
        check_val("ready_after_release", 32'(wr_ready_o), 32'd1);
        frames = 0;
        repeat (PERIOD * 2 - 1) begin
            cycle();
            frames += int'(frame_o);
        end
        check_val("frames_in_2_periods", frames, 2);

        // Duty on LED 1.
        write(3'd1, 4'd8, 4'd0, 4'd15);
        wait_frame();
        count_period();
        check_val("led1_red_on", cnt[1][0], 16);
        check_val("led1_green_on", cnt[1][1], 0);
        check_val("led1_blue_on", cnt[1][2], 30);
        others = 0;
        for (int i = 0; i < NUM_LEDS; i++)
            if (i != 1) others += cnt[i][0] + cnt[i][1] + cnt[i][2];
        check_val("other_leds_off", others, 0);

        // Double buffering: two back-to-back writes mid-period, last wins next period.
        repeat (10) cycle();
        write(3'd0, 4'd4, 4'd0, 4'd0);
        write(3'd0, 4'd12, 4'd0, 4'd0);
        red0 = 0;
        for (int i = 0; i < PERIOD + 8 && !frame_o; i++) begin
            cycle();
            if (!frame_o) red0 += int'(rgb_leds[0].r);
        end
        check_val("led0_current_period", red0, 0);
        check_val("led0_frame_seen", 32'(frame_o), 32'd1);
        count_period();
        check_val("led0_red_on", cnt[0][0], 24);

        // Boundary stall: valid held high for three periods.
        hs_dut = 0;
        hs_exp = 0;
        low_rdy = 0;
        wr_valid_i = 1'b1;
        for (int t = 0; t < PERIOD * 3; t++) begin
            wr_led_i   = 3'($urandom_range(0, NUM_LEDS - 1));
            wr_red_i   = 4'($urandom);
            wr_green_i = 4'($urandom);
            wr_blue_i  = 4'($urandom);
            if (!wr_ready_o) low_rdy++;
            cycle();
        end
        wr_valid_i = 1'b0;
        check_val("stall_handshakes", hs_dut, PERIOD * 3 - 3);
        check_val("stall_ready_low", low_rdy, 3);
        check_val("stall_hs_vs_model", hs_dut, hs_exp);

        // Out-of-range index.
        while (!m_ready || ((k % PERIOD) == PERIOD - 2)) cycle();
        write(3'd5, 4'd3, 4'd3, 4'd3);
        check_val("oor_err_pulse", 32'(wr_err_o), 32'd1);
        cycle();
        check_val("oor_err_single", 32'(wr_err_o), 32'd0);

        // Random traffic including out-of-range indices.
        for (int t = 0; t < 200; t++) begin
            wr_valid_i = 1'($urandom_range(0, 1));
            wr_led_i   = 3'($urandom);
            wr_red_i   = 4'($urandom);
            wr_green_i = 4'($urandom);
            wr_blue_i  = 4'($urandom);
            cycle();
        end
        wr_valid_i = 1'b0;

        // Reset during operation with all LEDs at nonzero duty.
        for (int i = 0; i < NUM_LEDS; i++) begin
            while (!m_ready) cycle();
            write(3'(i), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                  4'($urandom_range(1, 15)));
        end
        wait_frame();
        repeat (10) cycle();
        check_val("pre_reset_leds_nonzero", 32'(leds_flat != '0), 32'd1);
        wr_valid_i = 1'b1;
        wr_led_i   = 3'd2;
        wr_red_i   = 4'd9;
        do_reset(3);
        wr_valid_i = 1'b0;
        others = 0;
        repeat (PERIOD + 8) begin
            cycle();
            others += int'(leds_flat != '0);
        end
        check_val("post_reset_leds_off", others, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
